// File: rtl/if_id_stage_pkg.sv
// Pipeline constants and IF/ID register layout shared by fetch, decode and the
// hazard detector.
package if_id_stage_pkg;

   localparam int          INSTR_W       = 32;
   localparam int          PC_W          = 32;
   localparam int          CNT_W_DEF     = 16;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;   // sll $0,$0,0
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ACT_ADVANCE  = 2'd0,
      ACT_REDIRECT = 2'd1,
      ACT_STALL    = 2'd2
   } if_action_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc_plus4;
      logic               valid;
   } if_id_reg_t;

endpackage

// File: rtl/if_id_stage_sat_counter.sv
// Saturating event counter with async active-low clear.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, IF/ID pipeline register, stall/redirect priority
// select and stall/flush performance counters.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter int          CNT_W     = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             RAL_hazard,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic [31:0]      imem_instr,
   output logic [31:0]      pc,
   output logic [31:0]      IF_ID_instr,
   output logic [31:0]      IF_ID_pcPlus4,
   output logic             IF_ID_valid,
   output logic             ID_EX_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   if_id_reg_t  ifid_q, ifid_d;
   if_action_e  action;

   assign pc_plus4 = pc_q + 32'd4;

   // Stall beats redirect: the branch in ID may depend on the stalled load.
   always_comb begin
      action = ACT_ADVANCE;
      if (RAL_hazard)        action = ACT_STALL;
      else if (branch_taken) action = ACT_REDIRECT;
   end

   always_comb begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      case (action)
         ACT_REDIRECT: begin
            pc_d   = branch_target;
            ifid_d = '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
         end
         ACT_ADVANCE: begin
            pc_d   = pc_plus4;
            ifid_d = '{instr: imem_instr, pc_plus4: pc_plus4, valid: 1'b1};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q   <= RESET_PC;
         ifid_q <= '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
      end else begin
         pc_q   <= pc_d;
         ifid_q <= ifid_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clock),
      .rst_n_i (reset_n),
      .inc_i   (action == ACT_STALL),
      .cnt_o   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clock),
      .rst_n_i (reset_n),
      .inc_i   (action == ACT_REDIRECT),
      .cnt_o   (flush_cnt)
   );

   assign pc            = pc_q;
   assign IF_ID_instr   = ifid_q.instr;
   assign IF_ID_pcPlus4 = ifid_q.pc_plus4;
   assign IF_ID_valid   = ifid_q.valid;
   assign ID_EX_bubble  = RAL_hazard & ifid_q.valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed plus random bench for if_id_stage against a cycle-level reference model.
module tb_if_id_stage;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        RAL_hazard;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_instr;
   logic [31:0] pc;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_pcPlus4;
   logic        IF_ID_valid;
   logic        ID_EX_bubble;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_pc, m_instr, m_p4;
   logic        m_valid;
   logic [15:0] m_stall, m_flush;
   logic        hash_mode = 1'b0;

   if_id_stage dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .RAL_hazard    (RAL_hazard),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_instr    (imem_instr),
      .pc            (pc),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_pcPlus4 (IF_ID_pcPlus4),
      .IF_ID_valid   (IF_ID_valid),
      .ID_EX_bubble  (ID_EX_bubble),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] imem_f(input logic [31:0] a);
      if (hash_mode) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      return 32'h2000_0000 + a;
   endfunction

   always_comb imem_instr = imem_f(pc);

   task automatic model_reset();
      m_pc = 32'd0; m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
      m_stall = 16'd0; m_flush = 16'd0;
   endtask

   task automatic model_edge();
      if (RAL_hazard) begin
         if (m_stall != CNT_MAX) m_stall = m_stall + 16'd1;
      end else if (branch_taken) begin
         m_pc = branch_target; m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
         if (m_flush != CNT_MAX) m_flush = m_flush + 16'd1;
      end else begin
         m_instr = imem_f(m_pc); m_p4 = m_pc + 32'd4; m_valid = 1'b1;
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk32({tag, ".pc"},    pc, m_pc);
      chk32({tag, ".instr"}, IF_ID_instr, m_instr);
      chk32({tag, ".p4"},    IF_ID_pcPlus4, m_p4);
      chk32({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, m_valid});
      chk32({tag, ".stall"}, {16'd0, stall_cnt}, {16'd0, m_stall});
      chk32({tag, ".flush"}, {16'd0, flush_cnt}, {16'd0, m_flush});
      chk32({tag, ".bubble"}, {31'd0, ID_EX_bubble}, {31'd0, RAL_hazard & m_valid});
   endtask

   // Inputs are set right after this returns (1 ns past the edge).
   task automatic step(input string tag, input logic hz, input logic bt, input logic [31:0] tgt);
      RAL_hazard = hz; branch_taken = bt; branch_target = tgt;
      #1;
      chk32({tag, ".pre_bubble"}, {31'd0, ID_EX_bubble}, {31'd0, hz & m_valid});
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset_n = 1'b0; RAL_hazard = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
      model_reset();
      #12;
      check_all("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;

      // first edge after release was ADVANCE from 0
      model_edge();
      check_all("rel");
      repeat (3) step("free", 1'b0, 1'b0, 32'd0);
      chk32("free4.pc", pc, 32'd16);
      chk32("free4.instr", IF_ID_instr, 32'h2000_000C);

      // fresh run for load-use stall at pc=8
      reset_n = 1'b0; #1; model_reset(); reset_n = 1'b1;
      @(posedge clock); #1; model_edge();
      step("adv", 1'b0, 1'b0, 32'd0);
      chk32("pre_stall.pc", pc, 32'd8);
      step("stall", 1'b1, 1'b0, 32'd0);
      chk32("stall.pc", pc, 32'd8);
      chk32("stall.cnt", {16'd0, stall_cnt}, 32'd1);
      step("post_stall", 1'b0, 1'b0, 32'd0);
      chk32("post_stall.pc", pc, 32'd12);

      repeat (2) step("adv2", 1'b0, 1'b0, 32'd0);
      chk32("pre_br.pc", pc, 32'd20);
      step("redir", 1'b0, 1'b1, 32'h0000_0100);
      chk32("redir.pc", pc, 32'h100);
      chk32("redir.valid", {31'd0, IF_ID_valid}, 32'd0);
      step("redir_next", 1'b0, 1'b0, 32'd0);
      chk32("redir_next.p4", IF_ID_pcPlus4, 32'h104);

      step("both", 1'b1, 1'b1, 32'h0000_0400);
      chk32("both.pc", pc, 32'h104);
      step("br_after", 1'b0, 1'b1, 32'h0000_0400);
      chk32("br_after.pc", pc, 32'h400);
      step("stall_inv", 1'b1, 1'b0, 32'd0);

      // pc wrap
      step("to_top", 1'b0, 1'b1, 32'hFFFF_FFF8);
      step("top1", 1'b0, 1'b0, 32'd0);
      step("top2", 1'b0, 1'b0, 32'd0);
      chk32("wrap.pc", pc, 32'd0);
      chk32("wrap.p4", IF_ID_pcPlus4, 32'd0);

      // random traffic, unaligned targets allowed
      hash_mode = 1'b1;
      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(3) == 0), ($urandom_range(4) == 0), $urandom);
      hash_mode = 1'b0;

      // counter saturation
      RAL_hazard = 1'b1; branch_taken = 1'b0;
      for (int i = 0; i < 65539; i++) begin
         @(posedge clock);
         model_edge();
      end
      #1;
      check_all("sat");
      chk32("sat.stall", {16'd0, stall_cnt}, 32'h0000_FFFF);

      // async reset mid-stall, between edges
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #3;
      reset_n = 1'b1;
      RAL_hazard = 1'b0;
      @(posedge clock); model_edge(); #1;
      check_all("rst_adv");
      chk32("rst_adv.pc", pc, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
